// File: rtl/pw_bist_pkg.sv
// pw_bist_pkg -- shared definitions for the pointwise BIST driver.
//   bist_state_e    : driver FSM states (IDLE, RUN, DRAIN, DONE)
//   PW_LFSR_TAPS    : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   PW_DEFAULT_SEED : default generator load value
package pw_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [15:0] PW_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] PW_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/pw_lfsr16.sv
// pw_lfsr16 -- Fibonacci shift register usable as a pattern generator
// (din tied to 0) or as a MISR (din = response word).
// Ports:
//   clk, rst  : clock, synchronous active-high reset (loads RST_VAL)
//   load      : load load_val (has priority over en)
//   load_val  : value loaded when load=1
//   en        : advance one step: next = {q[W-2:0], fb} ^ din
//   din       : word XORed into the next state when advancing
//   q         : current register state
module pw_lfsr16
  import pw_bist_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(PW_LFSR_TAPS);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic             fb;

  always_comb begin
    // Feedback is the XOR of the tapped bits of the current state.
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (en) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb} ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= RST_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/pointwise_bist_driver.sv
// pointwise_bist_driver -- drives LFSR stimulus into a fixed-latency wrapped
// DUT and compacts the responses into a MISR signature.
// Ports:
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   start        : begin a run (only looked at in IDLE)
//   num_vectors  : vectors per run, latched when a run is accepted
//   dut_in       : stimulus to the wrapper (0 outside RUN)
//   dut_out      : wrapper response, LATENCY cycles behind dut_in
//   busy         : high in RUN and DRAIN
//   done         : one-cycle pulse in DONE
//   signature    : MISR value, held until the next accepted start
// Optional (macro PW_BIST_CHECK_EN):
//   expected_sig : reference signature
//   pass         : 1 in DONE iff signature == expected_sig; held until next start
module pointwise_bist_driver
  import pw_bist_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               LATENCY = 2,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(PW_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
`ifdef PW_BIST_CHECK_EN
  ,
  input  logic [WIDTH-1:0] expected_sig,
  output logic             pass
`endif
);

  bist_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LATENCY-1:0] vsr_q, vsr_d;
  logic [LATENCY-1:0] vsr_shift;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gen_load, gen_en, misr_load;
  logic [WIDTH-1:0]   gen_q, misr_q;

  // Valid pipeline: bit 0 marks a vector launched this cycle, the tail
  // lines up with the cycle its response is on dut_out.
  assign vsr_shift[0] = (state_q == ST_RUN);
  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vsr
    assign vsr_shift[gi] = vsr_q[gi-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gen_load  = 1'b0;
    gen_en    = 1'b0;
    misr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          misr_load = 1'b1;
          if (num_vectors != '0) begin
            cnt_d    = num_vectors;
            gen_load = 1'b1;
            state_d  = ST_RUN;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        gen_en = 1'b1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Counter is reused to time the drain window.
          cnt_d   = CNT_W'(LATENCY);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    vsr_d  = gen_load ? '0 : vsr_shift;
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

`ifdef PW_BIST_CHECK_EN
  logic pass_q, pass_d;
  logic sig_match;

  assign sig_match = (misr_q == expected_sig);

  always_comb begin
    pass_d = pass_q;
    if (state_q == ST_DONE) begin
      pass_d = sig_match;
    end else if (misr_load) begin
      pass_d = 1'b0;
    end
  end

  // In DONE the live comparison is shown; afterwards the latched verdict.
  assign pass = (state_q == ST_DONE) ? sig_match : pass_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      vsr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PW_BIST_CHECK_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vsr_q   <= vsr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PW_BIST_CHECK_EN
      pass_q  <= pass_d;
`endif
    end
  end

  pw_lfsr16 #(
    .WIDTH   (WIDTH),
    .RST_VAL (SEED)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (gen_load),
    .load_val (SEED),
    .en       (gen_en),
    .din      ('0),
    .q        (gen_q)
  );

  pw_lfsr16 #(
    .WIDTH   (WIDTH),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .load_val ('0),
    .en       (vsr_q[LATENCY-1]),
    .din      (dut_out),
    .q        (misr_q)
  );

  assign dut_in    = (state_q == ST_RUN) ? gen_q : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = misr_q;

endmodule

// File: tb/tb_pointwise_bist_driver.sv
// Bench for pointwise_bist_driver with an identity wrapper model (two
// register stages, LATENCY=2). Expected per-cycle outputs and signatures are
// pushed to scoreboard queues by a reference model, then popped and compared
// against captured DUT outputs. Build with +define+PW_BIST_CHECK_EN to also
// exercise expected_sig/pass.
module tb_pointwise_bist_driver;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 2;
  localparam int CNT_W   = 16;
  localparam int MAXC    = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [WIDTH-1:0] dut_in;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] signature;
`ifdef PW_BIST_CHECK_EN
  logic [WIDTH-1:0] expected_sig;
  logic             pass;
  logic             obs_pass [MAXC+1];
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [17:0] obs_ctl [MAXC+1];   // {busy, done, dut_in}
  logic [15:0] obs_sig [MAXC+1];

  logic [17:0] exp_ctl_q [$];
  logic [15:0] exp_sig_q [$];
  int          exp_done_c_q [$];

  always #5 clk = ~clk;

  pointwise_bist_driver #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W),
    .SEED    (16'hACE1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vectors  (num_vectors),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .signature    (signature)
`ifdef PW_BIST_CHECK_EN
    ,
    .expected_sig (expected_sig),
    .pass         (pass)
`endif
  );

  // Identity wrapper: input register then output register; flip corrupts bit 0.
  logic [WIDTH-1:0] wrap_in_reg;
  logic             flip;
  always @(posedge clk) begin
    wrap_in_reg <= dut_in ^ {{(WIDTH-1){1'b0}}, flip};
    dut_out     <= wrap_in_reg;
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference model: per-cycle {busy,done,dut_in} for cycles 1..win after
  // the start-sampling edge, plus final signature and the done cycle.
  task automatic push_expect(input int n, input int win, input bit corrupt);
    logic [15:0] s;
    logic [15:0] m;
    logic [15:0] resp;
    logic        b;
    logic        d;
    logic [15:0] din;
    int          done_c;
    s      = 16'hACE1;
    m      = 16'h0000;
    done_c = (n == 0) ? 1 : n + LATENCY + 1;
    for (int c = 1; c <= win; c++) begin
      b   = (n > 0) && (c <= n + LATENCY);
      d   = (c == done_c);
      din = (c <= n) ? s : 16'h0000;
      exp_ctl_q.push_back({b, d, din});
      if (c <= n) begin
        resp = s ^ ((corrupt && c == n) ? 16'h0001 : 16'h0000);
        m    = ref_step(m) ^ resp;
        s    = ref_step(s);
      end
    end
    exp_sig_q.push_back(m);
    exp_done_c_q.push_back(done_c);
  endtask

  // Drives one run and captures outputs at each negedge (cycle 1 = the
  // cycle following the edge that samples start).
  task automatic drive_run(input int n, input int win, input int hold_cycles,
                           input bit pulses, input int rst_at, input bit corrupt);
    @(negedge clk);
    start       = 1'b1;
    num_vectors = CNT_W'(n);
    @(posedge clk);
    #1;
    if (hold_cycles == 0) start = 1'b0;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      obs_ctl[c] = {busy, done, dut_in};
      obs_sig[c] = signature;
`ifdef PW_BIST_CHECK_EN
      obs_pass[c] = pass;
`endif
      flip = corrupt && (c == n);
      if (hold_cycles > 0) begin
        start = (c < hold_cycles);
      end else if (pulses) begin
        start       = (c >= 2) && (c <= n + LATENCY) && (c % 2 == 0);
        num_vectors = start ? '0 : CNT_W'(n);
      end
      if (rst_at > 0) rst = (c == rst_at);
    end
    start = 1'b0;
    flip  = 1'b0;
    rst   = 1'b0;
    $display("run n=%0d window=%0d signature=%h", n, win, signature);
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    start       = 1'b1;   // reset must win over start
    num_vectors = 16'd3;
    flip        = 1'b0;
`ifdef PW_BIST_CHECK_EN
    expected_sig = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (dut_in !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset dut_in got %h want 0000", dut_in);
    end
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset busy/done got %0b%0b want 00", busy, done);
    end
    vectors++;
    if (signature !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset signature got %h want 0000", signature);
    end
`ifdef PW_BIST_CHECK_EN
    vectors++;
    if (pass !== 1'b0) begin
      miscompares++;
      $display("FAIL reset pass got %0b want 0", pass);
    end
`endif
    start = 1'b0;
    rst   = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_single;
    logic [17:0] e;
    logic [15:0] es;
    int          dc;
    push_expect(1, 6, 1'b0);
    drive_run(1, 6, 0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL single c=%0d busy,done,dut_in got %0b,%0b,%h want %0b,%0b,%h",
                 c, obs_ctl[c][17], obs_ctl[c][16], obs_ctl[c][15:0], e[17], e[16], e[15:0]);
      end
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es || obs_sig[4] !== 16'hACE1) begin
      miscompares++;
      $display("FAIL single signature got %h want %h (ACE1)", obs_sig[dc], es);
    end
    vectors++;
    if (obs_ctl[4][16] !== 1'b1) begin
      miscompares++;
      $display("FAIL single done_at_4 got %0b want 1", obs_ctl[4][16]);
    end
  endtask

  task automatic test_two;
    logic [17:0] e;
    logic [15:0] es;
    int          dc;
    int          busy_cnt;
    push_expect(2, 7, 1'b0);
    drive_run(2, 7, 0, 1'b0, 0, 1'b0);
    busy_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      e = exp_ctl_q.pop_front();
      if (obs_ctl[c][17] === 1'b1) busy_cnt++;
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL two c=%0d busy,done,dut_in got %0b,%0b,%h want %0b,%0b,%h",
                 c, obs_ctl[c][17], obs_ctl[c][16], obs_ctl[c][15:0], e[17], e[16], e[15:0]);
      end
    end
    vectors++;
    if (obs_ctl[2][15:0] !== 16'h59C3) begin
      miscompares++;
      $display("FAIL two second_vector got %h want 59c3", obs_ctl[2][15:0]);
    end
    vectors++;
    if (busy_cnt != 4) begin
      miscompares++;
      $display("FAIL two busy_cycles got %0d want 4", busy_cnt);
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es || obs_sig[7] !== es) begin
      miscompares++;
      $display("FAIL two signature got %h/%h want %h", obs_sig[dc], obs_sig[7], es);
    end
  endtask

  task automatic test_zero;
    logic [17:0] e;
    logic [15:0] es;
    int          dc;
    push_expect(0, 3, 1'b0);
    drive_run(0, 3, 0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL zero c=%0d busy,done,dut_in got %0b,%0b,%h want %0b,%0b,%h",
                 c, obs_ctl[c][17], obs_ctl[c][16], obs_ctl[c][15:0], e[17], e[16], e[15:0]);
      end
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es) begin
      miscompares++;
      $display("FAIL zero signature got %h want %h", obs_sig[dc], es);
    end
  endtask

  task automatic test_mid_reset;
    logic [17:0] e;
    logic [15:0] es;
    logic [15:0] s;
    int          dc;
    // Interrupted run: reset asserted during vector 5 of 10.
    drive_run(10, 10, 0, 1'b0, 5, 1'b0);
    s = 16'hACE1;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if (obs_ctl[c] !== {2'b10, s}) begin
        miscompares++;
        $display("FAIL midrst c=%0d ctl got %h want %h", c, obs_ctl[c], {2'b10, s});
      end
      s = ref_step(s);
    end
    for (int c = 6; c <= 10; c++) begin
      vectors++;
      if (obs_ctl[c] !== 18'h0 || obs_sig[c] !== 16'h0000) begin
        miscompares++;
        $display("FAIL midrst_idle c=%0d ctl got %h sig %h want 0/0", c, obs_ctl[c], obs_sig[c]);
      end
    end
    // Fresh full run must match an uninterrupted 10-vector reference.
    push_expect(10, 14, 1'b0);
    drive_run(10, 14, 0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL restart c=%0d ctl got %h want %h", c, obs_ctl[c], e);
      end
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es) begin
      miscompares++;
      $display("FAIL restart signature got %h want %h", obs_sig[dc], es);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] e;
    logic [15:0] es;
    int          dc;
    // Start held: second run accepted in the IDLE cycle after DONE.
    push_expect(2, 6, 1'b0);
    push_expect(2, 6, 1'b0);
    drive_run(2, 12, 2 + LATENCY + 3, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL b2b c=%0d ctl got %h want %h", c, obs_ctl[c], e);
      end
    end
    for (int r = 0; r < 2; r++) begin
      es = exp_sig_q.pop_front();
      dc = exp_done_c_q.pop_front() + r * 6;
      vectors++;
      if (obs_sig[dc] !== es) begin
        miscompares++;
        $display("FAIL b2b run%0d signature got %h want %h", r, obs_sig[dc], es);
      end
    end
  endtask

  task automatic test_busy_pulses;
    logic [17:0] e;
    logic [15:0] es;
    int          dc;
    push_expect(4, 9, 1'b0);
    drive_run(4, 9, 0, 1'b1, 0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL pulses c=%0d ctl got %h want %h", c, obs_ctl[c], e);
      end
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es) begin
      miscompares++;
      $display("FAIL pulses signature got %h want %h", obs_sig[dc], es);
    end
  endtask

  task automatic test_check;
    logic [17:0] e;
    logic [15:0] good_sig;
    logic [15:0] es;
    int          dc;
    // Clean run, reference signature applied as expected_sig.
    push_expect(3, 7, 1'b0);
    good_sig = exp_sig_q[exp_sig_q.size()-1];
`ifdef PW_BIST_CHECK_EN
    expected_sig = good_sig;
`endif
    drive_run(3, 7, 0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 7; c++) void'(exp_ctl_q.pop_front());
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es) begin
      miscompares++;
      $display("FAIL check_clean signature got %h want %h", obs_sig[dc], es);
    end
`ifdef PW_BIST_CHECK_EN
    vectors++;
    if (obs_pass[dc] !== 1'b1 || obs_pass[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL check_clean pass got %0b/%0b want 1/1", obs_pass[dc], obs_pass[7]);
    end
`endif
    // Bit 0 of the last response corrupted in the wrapper.
    push_expect(3, 7, 1'b1);
    drive_run(3, 7, 0, 1'b0, 0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      e = exp_ctl_q.pop_front();
      vectors++;
      if (obs_ctl[c] !== e) begin
        miscompares++;
        $display("FAIL check_corrupt c=%0d ctl got %h want %h", c, obs_ctl[c], e);
      end
    end
    es = exp_sig_q.pop_front();
    dc = exp_done_c_q.pop_front();
    vectors++;
    if (obs_sig[dc] !== es || es === good_sig) begin
      miscompares++;
      $display("FAIL check_corrupt signature got %h want %h", obs_sig[dc], es);
    end
`ifdef PW_BIST_CHECK_EN
    vectors++;
    if (obs_pass[1] !== 1'b0 || obs_pass[dc] !== 1'b0 || obs_pass[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL check_corrupt pass got %0b/%0b/%0b want 0/0/0",
               obs_pass[1], obs_pass[dc], obs_pass[7]);
    end
`endif
  endtask

  initial begin
    start       = 1'b0;
    rst         = 1'b1;
    num_vectors = '0;
    flip        = 1'b0;
    test_reset();
    test_single();
    test_two();
    test_zero();
    test_mid_reset();
    test_back_to_back();
    test_busy_pulses();
    test_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
